// File: rtl/bus_dma_master_pkg.sv
// Shared definitions for the block-copy bus master: bus widths and FSM state encoding.
package bus_dma_master_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_RDW,
      S_WR,
      S_DONE
   } state_t;

endpackage

// File: rtl/bus_dma_master_if.sv
// Bus master port bundle: request/grant handshake plus address, write strobe and data paths.
interface bus_dma_master_if;
   import bus_dma_master_pkg::*;

   logic              m_req;
   logic              m_grant;
   logic              m_wr;
   logic [ADDR_W-1:0] m_address;
   logic [DATA_W-1:0] m_dout;
   logic [DATA_W-1:0] m_din;

   modport master (
      output m_req,
      output m_wr,
      output m_address,
      output m_dout,
      input  m_grant,
      input  m_din
   );

   modport slave (
      input  m_req,
      input  m_wr,
      input  m_address,
      input  m_dout,
      output m_grant,
      output m_din
   );

endinterface

// File: rtl/bus_dma_master.sv
// Word-at-a-time block copier: holds the bus from first grant to final write, one RD/RDW/WR
// triple per word, and restarts the current word from RD whenever the grant is withdrawn.
module bus_dma_master
   import bus_dma_master_pkg::*;
#(
   parameter int                LEN_W    = 8,
   parameter logic [ADDR_W-1:0] ADDR_INC = 16'd1
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   bus_dma_master_if.master  bus
);

   state_t            state;
   logic [ADDR_W-1:0] cur_src;
   logic [ADDR_W-1:0] cur_dst;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] data_reg;

   // The captured read word doubles as the write-data register.
   assign bus.m_dout = data_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         bus.m_req     <= 1'b0;
         bus.m_wr      <= 1'b0;
         bus.m_address <= '0;
         cur_src       <= '0;
         cur_dst       <= '0;
         remaining     <= '0;
         data_reg      <= '0;
      end else begin
         done     <= 1'b0;
         bus.m_wr <= 1'b0;
         if (abort && state != S_IDLE) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            bus.m_req <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (len == '0) begin
                        done <= 1'b1;
                     end else begin
                        state     <= S_REQ;
                        busy      <= 1'b1;
                        bus.m_req <= 1'b1;
                        cur_src   <= src_addr;
                        cur_dst   <= dst_addr;
                        remaining <= len;
                     end
                  end
               end
               S_REQ: begin
                  if (bus.m_grant) begin
                     state         <= S_RD;
                     bus.m_address <= cur_src;
                  end
               end
               S_RD: begin
                  state <= bus.m_grant ? S_RDW : S_REQ;
               end
               S_RDW: begin
                  if (!bus.m_grant) begin
                     state <= S_REQ;
                  end else begin
                     state         <= S_WR;
                     data_reg      <= bus.m_din;
                     bus.m_address <= cur_dst;
                     bus.m_wr      <= 1'b1;
                  end
               end
               S_WR: begin
                  if (!bus.m_grant) begin
                     state <= S_REQ;
                  end else begin
                     cur_src   <= cur_src + ADDR_INC;
                     cur_dst   <= cur_dst + ADDR_INC;
                     remaining <= remaining - LEN_W'(1);
                     if (remaining == LEN_W'(1)) begin
                        state     <= S_DONE;
                        bus.m_req <= 1'b0;
                        done      <= 1'b1;
                     end else begin
                        state         <= S_RD;
                        bus.m_address <= cur_src + ADDR_INC;
                     end
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  bus.m_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: behavioural slave memory and arbiter, reference copy model feeding
// an expected-write/expected-done scoreboard that a negedge monitor drains.
module tb_bus_dma_master;
   import bus_dma_master_pkg::*;

   typedef struct packed {
      logic [15:0] addr;
      logic [63:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [7:0]  len;
   logic        busy;
   logic        done;

   bus_dma_master_if bus();

   bus_dma_master #(.LEN_W(8), .ADDR_INC(16'd1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int busy_cycles = 0;
   bit req_seen = 1'b0;

   wr_t exp_q[$];
   int  done_q[$];
   wr_t mon_e;

   logic [63:0] mem       [0:65535];
   logic [63:0] model_mem [0:65535];
   logic [63:0] rdata = 64'h0;

   // Slave: registered read, write committed at the edge ending a granted write cycle.
   always @(posedge clk) begin
      if (bus.m_grant && bus.m_wr) mem[bus.m_address] <= bus.m_dout;
      if (bus.m_grant && !bus.m_wr) rdata <= mem[bus.m_address];
   end
   assign bus.m_din = rdata;

   // Arbiter: registered grant after gnt_delay extra cycles of request; force_drop withdraws it.
   int   gnt_delay = 0;
   int   req_cnt = 0;
   bit   force_drop = 1'b0;
   logic gnt = 1'b0;
   always @(posedge clk) begin
      if (!bus.m_req || force_drop) begin
         gnt     <= 1'b0;
         req_cnt <= 0;
      end else if (req_cnt >= gnt_delay) begin
         gnt <= 1'b1;
      end else begin
         req_cnt <= req_cnt + 1;
      end
   end
   assign bus.m_grant = gnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every granted write and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (reset_n) begin
         if (busy) busy_cycles++;
         if (bus.m_req) req_seen = 1'b1;
         if (bus.m_wr) check("wr_needs_grant", 64'(bus.m_grant), 64'd1);
         if (bus.m_wr && bus.m_grant) begin
            if (exp_q.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %h data %h expected no write",
                        bus.m_address, bus.m_dout);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", 64'(bus.m_address), 64'(mon_e.addr));
               check("wr_data", bus.m_dout, mon_e.data);
               $display("write addr=%h data=%h", bus.m_address, bus.m_dout);
            end
         end
         if (done) begin
            n_assert++;
            if (done_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
               void'(done_q.pop_front());
               $display("done");
            end
         end
      end
   end

   // Reference copy: sequential word moves over the model memory, 16-bit wrapping addresses.
   task automatic push_expect(input logic [15:0] s, input logic [15:0] d, input int n,
                              input bit want_done);
      logic [15:0] sa;
      logic [15:0] da;
      wr_t e;
      for (int i = 0; i < n; i++) begin
         sa = s + 16'(i);
         da = d + 16'(i);
         model_mem[da] = model_mem[sa];
         e.addr = da;
         e.data = model_mem[da];
         exp_q.push_back(e);
      end
      if (want_done) done_q.push_back(1);
   endtask

   task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input int l,
                              input bit with_abort);
      @(negedge clk);
      busy_cycles = 0;
      req_seen    = 1'b0;
      src_addr = s;
      dst_addr = d;
      len      = 8'(l);
      start    = 1'b1;
      abort    = with_abort;
      $display("start src=%h dst=%h len=%0d abort=%0d", s, d, l, with_abort);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busy == 1'b0 && exp_q.size() == 0 && done_q.size() == 0) && n < budget);
      check({name, "_drained"}, 64'(exp_q.size() + done_q.size()), 64'd0);
   endtask

   task automatic wait_wr(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.m_wr && n < budget);
      check({name, "_wr_seen"}, 64'(bus.m_wr), 64'd1);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_done"}, 64'(done), 64'd0);
      check({name, "_m_req"}, 64'(bus.m_req), 64'd0);
      check({name, "_m_wr"}, 64'(bus.m_wr), 64'd0);
      check({name, "_m_address"}, 64'(bus.m_address), 64'd0);
      check({name, "_m_dout"}, bus.m_dout, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      logic [63:0] ref_abc [3];
      logic [15:0] rs;
      logic [15:0] rd;
      int          rl;

      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      src_addr = 16'h0;
      dst_addr = 16'h0;
      len      = 8'h0;
      for (int a = 0; a < 65536; a++) begin
         v = {$urandom, $urandom};
         mem[a] <= v;
         model_mem[a] = v;
      end
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset_n = 1'b1;

      // Basic copy of three words with the fastest grant.
      gnt_delay = 0;
      for (int i = 0; i < 3; i++) ref_abc[i] = model_mem[16'h0010 + 16'(i)];
      push_expect(16'h0010, 16'h0100, 3, 1'b1);
      pulse_start(16'h0010, 16'h0100, 3, 1'b0);
      wait_idle("copy3", 200);
      check("copy3_busy_cycles", 64'(busy_cycles), 64'(gnt_delay + 2 + 3 * 3 + 1));
      for (int i = 0; i < 3; i++) check("copy3_mem", mem[16'h0100 + 16'(i)], ref_abc[i]);

      // Zero length: done next cycle, no bus activity.
      done_q.push_back(1);
      pulse_start(16'h0020, 16'h0200, 0, 1'b0);
      check("len0_done_next", 64'(done), 64'd1);
      @(negedge clk);
      check("len0_done_pulse", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      check("len0_req", 64'(req_seen), 64'd0);
      check("len0_busy", 64'(busy_cycles), 64'd0);
      check("len0_done_seen", 64'(done_q.size()), 64'd0);

      // Slow grant; a second start during the wait must not disturb the latched config.
      gnt_delay = 5;
      push_expect(16'h0030, 16'h0300, 3, 1'b1);
      pulse_start(16'h0030, 16'h0300, 3, 1'b0);
      src_addr = 16'h5555;
      dst_addr = 16'h6666;
      len      = 8'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("slowgnt", 300);
      check("slowgnt_busy_cycles", 64'(busy_cycles), 64'(gnt_delay + 2 + 3 * 3 + 1));

      // Grant withdrawn during RDW of word 2.
      gnt_delay = 0;
      push_expect(16'h0040, 16'h0400, 3, 1'b1);
      pulse_start(16'h0040, 16'h0400, 3, 1'b0);
      wait_wr("drop", 50);
      @(negedge clk);
      force_drop = 1'b1;
      @(negedge clk);
      check("drop_grant_low", 64'(bus.m_grant), 64'd0);
      force_drop = 1'b0;
      wait_idle("drop", 200);
      check("drop_took_longer", 64'(busy_cycles > 12), 64'd1);

      // Abort in the first word's write: that write lands, nothing after it, no done.
      push_expect(16'h0050, 16'h0500, 1, 1'b0);
      pulse_start(16'h0050, 16'h0500, 4, 1'b0);
      wait_wr("abort", 50);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_m_req", 64'(bus.m_req), 64'd0);
      check("abort_m_wr", 64'(bus.m_wr), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      repeat (12) @(negedge clk);
      check("abort_no_more", 64'(exp_q.size()), 64'd0);

      // Abort together with start in IDLE: start wins.
      push_expect(16'h0070, 16'h0710, 1, 1'b1);
      pulse_start(16'h0070, 16'h0710, 1, 1'b1);
      wait_idle("start_wins", 100);

      // Source address wrap.
      push_expect(16'hFFFF, 16'h2000, 2, 1'b1);
      pulse_start(16'hFFFF, 16'h2000, 2, 1'b0);
      wait_idle("wrap", 100);

      // Asynchronous reset mid-copy, after one word has been written.
      push_expect(16'h0300, 16'h0400, 1, 1'b0);
      pulse_start(16'h0300, 16'h0400, 5, 1'b0);
      wait_wr("rst", 50);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("midreset_no_more", 64'(exp_q.size()), 64'd0);

      // Random copies with random grant latency.
      for (int k = 0; k < 6; k++) begin
         rs = 16'($urandom_range(0, 65535));
         rd = 16'($urandom_range(0, 65535));
         rl = int'($urandom_range(1, 8));
         gnt_delay = int'($urandom_range(0, 3));
         push_expect(rs, rd, rl, 1'b1);
         pulse_start(rs, rd, rl, 1'b0);
         wait_idle("rand", 400);
         check("rand_busy_cycles", 64'(busy_cycles), 64'(gnt_delay + 2 + 3 * rl + 1));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
